// File: rtl/pico_peri_pkg.sv
// Shared types and constants for the pico peripheral sequencing controller.
package pico_peri_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } peri_state_e;

    localparam logic [3:0]  PERI_REGION = 4'h1;
    localparam logic [31:0] DECERR_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] TOUT_DATA   = 32'hFFFF_FFFF;

    // Any byte enable set marks the access as a write.
    function automatic logic is_write(input logic [3:0] wstrb);
        return |wstrb;
    endfunction

endpackage

// File: rtl/pico_peri_ctrl_if.sv
// Core memory-port bundle between the RV32I core (master) and the controller (slave).
interface pico_peri_ctrl_if;

    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_rdata, cpu_ready
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_rdata, cpu_ready
    );

endinterface

// File: rtl/pico_peri_decode.sv
// Combinational region check, slot range check and one-hot slave select.
module pico_peri_decode
    import pico_peri_pkg::*;
#(
    parameter int NUM_SLV = 4
) (
    input  logic               i_valid,
    input  logic [3:0]         i_region,
    input  logic [3:0]         i_slot,
    output logic               o_accept,
    output logic               o_in_range,
    output logic [NUM_SLV-1:0] o_onehot
);

    assign o_accept   = i_valid && (i_region == PERI_REGION);
    assign o_in_range = ({1'b0, i_slot} < 5'(NUM_SLV));

    // One-hot slave select; all zero when the slot is out of range.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            o_onehot[i] = (i_slot == 4'(i));
        end
    end

endmodule

// File: rtl/pico_peri_ctrl.sv
// Peripheral sequencing controller: one strobe per core access, registered response.
// Optional slave timeout enabled by defining PERI_TIMEOUT_EN.
module pico_peri_ctrl
    import pico_peri_pkg::*;
#(
    parameter int NUM_SLV     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   resetn,
    pico_peri_ctrl_if.slave        io_cpu,
    output logic [NUM_SLV-1:0]     o_slv_rden,
    output logic [NUM_SLV-1:0]     o_slv_wren,
    output logic [31:0]            o_slv_addr,
    output logic [31:0]            o_slv_wdata,
    output logic [3:0]             o_slv_wstrb,
    input  logic [32*NUM_SLV-1:0]  i_slv_rdata,
    input  logic [NUM_SLV-1:0]     i_slv_ready,
    output logic                   o_err_irq,
    output logic [31:0]            o_err_addr
);

    peri_state_e        r_state;
    logic [NUM_SLV-1:0] r_sel;
    logic [NUM_SLV-1:0] r_slv_rden;
    logic [NUM_SLV-1:0] r_slv_wren;
    logic [31:0]        r_slv_addr;
    logic [31:0]        r_slv_wdata;
    logic [3:0]         r_slv_wstrb;
    logic [31:0]        r_cpu_rdata;
    logic               r_cpu_ready;
    logic               r_err_irq;
    logic [31:0]        r_err_addr;

    logic               w_accept;
    logic               w_in_range;
    logic [NUM_SLV-1:0] w_onehot;
    logic [31:0]        w_sel_rdata;
    logic               w_sel_ready;

`ifdef PERI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_tcnt;
`endif

    pico_peri_decode #(.NUM_SLV(NUM_SLV)) u_decode (
        .i_valid    (io_cpu.cpu_valid),
        .i_region   (io_cpu.cpu_addr[31:28]),
        .i_slot     (io_cpu.cpu_addr[19:16]),
        .o_accept   (w_accept),
        .o_in_range (w_in_range),
        .o_onehot   (w_onehot)
    );

    // Only the latched slave's ready and data are visible to the FSM.
    always_comb begin
        w_sel_rdata = 32'h0;
        for (int i = 0; i < NUM_SLV; i++) begin
            w_sel_rdata = w_sel_rdata | (i_slv_rdata[32*i +: 32] & {32{r_sel[i]}});
        end
    end
    assign w_sel_ready = |(i_slv_ready & r_sel);

    // Sequencing FSM with registered strobes, response and error reporting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_slv_rden  <= '0;
            r_slv_wren  <= '0;
            r_slv_addr  <= 32'h0;
            r_slv_wdata <= 32'h0;
            r_slv_wstrb <= 4'h0;
            r_cpu_rdata <= 32'h0;
            r_cpu_ready <= 1'b0;
            r_err_irq   <= 1'b0;
            r_err_addr  <= 32'h0;
`ifdef PERI_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
        end else begin
            r_slv_rden  <= '0;
            r_slv_wren  <= '0;
            r_cpu_ready <= 1'b0;
            r_err_irq   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_slv_addr  <= io_cpu.cpu_addr;
                        r_slv_wdata <= io_cpu.cpu_wdata;
                        r_slv_wstrb <= io_cpu.cpu_wstrb;
                        if (w_in_range) begin
                            r_sel <= w_onehot;
                            if (is_write(io_cpu.cpu_wstrb)) r_slv_wren <= w_onehot;
                            else                            r_slv_rden <= w_onehot;
`ifdef PERI_TIMEOUT_EN
                            r_tcnt <= '0;
`endif
                            r_state <= ISSUE;
                        end else begin
                            r_sel       <= '0;
                            r_cpu_ready <= 1'b1;
                            r_cpu_rdata <= DECERR_DATA;
                            r_err_irq   <= 1'b1;
                            r_err_addr  <= io_cpu.cpu_addr;
                            r_state     <= RESP;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE, WAIT: begin
                    if (w_sel_ready) begin
                        r_cpu_ready <= 1'b1;
                        r_cpu_rdata <= is_write(r_slv_wstrb) ? 32'h0 : w_sel_rdata;
                        r_state     <= RESP;
`ifdef PERI_TIMEOUT_EN
                    end else if (r_tcnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_cpu_ready <= 1'b1;
                        r_cpu_rdata <= TOUT_DATA;
                        r_err_irq   <= 1'b1;
                        r_err_addr  <= r_slv_addr;
                        r_state     <= RESP;
                    end else begin
                        r_tcnt  <= r_tcnt + CNT_W'(1);
                        r_state <= WAIT;
`else
                    end else begin
                        r_state <= WAIT;
`endif
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_cpu.cpu_rdata = r_cpu_rdata;
    assign io_cpu.cpu_ready = r_cpu_ready;
    assign o_slv_rden       = r_slv_rden;
    assign o_slv_wren       = r_slv_wren;
    assign o_slv_addr       = r_slv_addr;
    assign o_slv_wdata      = r_slv_wdata;
    assign o_slv_wstrb      = r_slv_wstrb;
    assign o_err_irq        = r_err_irq;
    assign o_err_addr       = r_err_addr;

endmodule
